axis_ingress_port: RTL and testbench



---
 rtl/axis_ingress_port_if.sv | 28 ++
 rtl/axis_ingress_port.sv | 127 ++++++++++++
 tb/tb_axis_ingress_port.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axis_ingress_port_if.sv
// AXI4-Stream bundle used on both sides of the ingress port.
// master drives payload and valid; slave drives ready.
interface axis_ingress_port_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata,
        output tvalid,
        input  tready,
        output tlast,
        output tuser
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready,
        input  tlast,
        input  tuser
    );
endinterface

// File: rtl/axis_ingress_port.sv
// Ingress boundary: zero-latency AXI4-Stream pass-through with a registered
// frame monitor (saturating statistics, in-frame flag, sticky protocol checker).
module axis_ingress_port #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_ingress_port_if.slave   s,
    axis_ingress_port_if.master  m,
    input  logic                 stat_clear,
    output logic [CNT_WIDTH-1:0] stat_frames,
    output logic [CNT_WIDTH-1:0] stat_beats,
    output logic [CNT_WIDTH-1:0] stat_err_frames,
    output logic                 stat_in_frame,
    output logic                 stat_proto_err
);

    typedef enum logic [0:0] {StIdle, StInFrame} state_e;

    state_e state_q, state_d;

    logic [CNT_WIDTH-1:0] frames_q, frames_d;
    logic [CNT_WIDTH-1:0] beats_q, beats_d;
    logic [CNT_WIDTH-1:0] err_frames_q, err_frames_d;
    logic                 proto_err_q, proto_err_d;

    logic                  prev_stalled_q;
    logic [DATA_WIDTH-1:0] rec_data_q;
    logic                  rec_last_q;
    logic [USER_WIDTH-1:0] rec_user_q;

    logic xfer;
    logic stalled;
    logic violation;

    // Datapath: no storage, reset only gates the handshake.
    assign m.tdata  = s.tdata;
    assign m.tlast  = s.tlast;
    assign m.tuser  = s.tuser;
    assign m.tvalid = s.tvalid & ~rst;
    assign s.tready = m.tready & ~rst;

    assign xfer    = s.tvalid & s.tready;
    assign stalled = s.tvalid & ~s.tready;

    // A stalled beat must stay valid and keep its payload until accepted.
    assign violation = prev_stalled_q &
                       (~s.tvalid |
                        (s.tdata != rec_data_q) |
                        (s.tlast != rec_last_q) |
                        (s.tuser != rec_user_q));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (xfer && !s.tlast) state_d = StInFrame;
            StInFrame: if (xfer && s.tlast)  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        frames_d     = frames_q;
        beats_d      = beats_q;
        err_frames_d = err_frames_q;
        proto_err_d  = proto_err_q;
        if (stat_clear) begin
            frames_d     = '0;
            beats_d      = '0;
            err_frames_d = '0;
            proto_err_d  = 1'b0;
        end else begin
            if (xfer) begin
                if (beats_q != '1) beats_d = beats_q + 1'b1;
                if (s.tlast) begin
                    if (frames_q != '1) frames_d = frames_q + 1'b1;
                    if (s.tuser[0] && (err_frames_q != '1)) begin
                        err_frames_d = err_frames_q + 1'b1;
                    end
                end
            end
            if (violation) proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            frames_q     <= '0;
            beats_q      <= '0;
            err_frames_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frames_q     <= frames_d;
            beats_q      <= beats_d;
            err_frames_q <= err_frames_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Stall record; stalls forced by reset are never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_stalled_q <= 1'b0;
            rec_data_q     <= '0;
            rec_last_q     <= 1'b0;
            rec_user_q     <= '0;
        end else begin
            prev_stalled_q <= stalled;
            if (stalled) begin
                rec_data_q <= s.tdata;
                rec_last_q <= s.tlast;
                rec_user_q <= s.tuser;
            end
        end
    end

    assign stat_frames     = frames_q;
    assign stat_beats      = beats_q;
    assign stat_err_frames = err_frames_q;
    assign stat_in_frame   = (state_q == StInFrame);
    assign stat_proto_err  = proto_err_q;

endmodule

// File: tb/tb_axis_ingress_port.sv
// Directed bench for axis_ingress_port: a 32-bit-counter instance for function
// and a 4-bit-counter instance sharing the same stimulus for saturation.
module tb_axis_ingress_port;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic [0:0] tuser;
    logic       m_tready;
    logic       stat_clear;

    logic [31:0] frames, beats, err_frames;
    logic        in_frame, proto_err;
    logic [3:0]  sat_frames, sat_beats, sat_err_frames;
    logic        sat_in_frame, sat_proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axis_ingress_port_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s_if ();
    axis_ingress_port_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m_if ();
    axis_ingress_port_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s_sat_if ();
    axis_ingress_port_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m_sat_if ();

    assign s_if.tdata      = tdata;
    assign s_if.tvalid     = tvalid;
    assign s_if.tlast      = tlast;
    assign s_if.tuser      = tuser;
    assign m_if.tready     = m_tready;
    assign s_sat_if.tdata  = tdata;
    assign s_sat_if.tvalid = tvalid;
    assign s_sat_if.tlast  = tlast;
    assign s_sat_if.tuser  = tuser;
    assign m_sat_if.tready = m_tready;

    axis_ingress_port #(.DATA_WIDTH(8), .USER_WIDTH(1), .CNT_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .s               (s_if),
        .m               (m_if),
        .stat_clear      (stat_clear),
        .stat_frames     (frames),
        .stat_beats      (beats),
        .stat_err_frames (err_frames),
        .stat_in_frame   (in_frame),
        .stat_proto_err  (proto_err)
    );

    axis_ingress_port #(.DATA_WIDTH(8), .USER_WIDTH(1), .CNT_WIDTH(4)) dut_sat (
        .clk             (clk),
        .rst             (rst),
        .s               (s_sat_if),
        .m               (m_sat_if),
        .stat_clear      (stat_clear),
        .stat_frames     (sat_frames),
        .stat_beats      (sat_beats),
        .stat_err_frames (sat_err_frames),
        .stat_in_frame   (sat_in_frame),
        .stat_proto_err  (sat_proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        tdata      = 8'h00;
        tvalid     = 1'b0;
        tlast      = 1'b0;
        tuser      = 1'b0;
        m_tready   = 1'b0;
        stat_clear = 1'b0;
        step();

        // Reset gates handshake while payload still passes through.
        m_tready = 1'b1;
        tvalid   = 1'b1;
        tdata    = 8'h5A;
        #1;
        check("rst_s_tready", {31'b0, s_if.tready}, 32'h0);
        check("rst_m_tvalid", {31'b0, m_if.tvalid}, 32'h0);
        check("rst_m_tdata", {24'b0, m_if.tdata}, 32'h5A);
        step();
        check("rst_beats", beats, 32'h0);
        check("rst_frames", frames, 32'h0);
        check("rst_in_frame", {31'b0, in_frame}, 32'h0);
        check("rst_proto", {31'b0, proto_err}, 32'h0);

        // Valid drops right after reset: the reset stall must not count.
        rst    = 1'b0;
        tvalid = 1'b0;
        m_tready = 1'b0;
        step();
        check("post_rst_no_proto", {31'b0, proto_err}, 32'h0);

        // Backpressure
        tvalid = 1'b1;
        tdata  = 8'h88;
        tlast  = 1'b1;
        #1;
        check("bp_s_tready", {31'b0, s_if.tready}, 32'h0);
        check("bp_m_tvalid", {31'b0, m_if.tvalid}, 32'h1);
        check("bp_m_tdata", {24'b0, m_if.tdata}, 32'h88);
        step();
        check("bp_beats", beats, 32'h0);

        // Release
        m_tready = 1'b1;
        #1;
        check("rel_s_tready", {31'b0, s_if.tready}, 32'h1);
        check("rel_m_tvalid", {31'b0, m_if.tvalid}, 32'h1);
        check("rel_m_tdata", {24'b0, m_if.tdata}, 32'h88);
        check("rel_m_tlast", {31'b0, m_if.tlast}, 32'h1);
        step();
        tvalid = 1'b0;
        check("rel_beats", beats, 32'h1);
        check("rel_frames", frames, 32'h1);
        check("rel_in_frame", {31'b0, in_frame}, 32'h0);
        check("rel_no_proto", {31'b0, proto_err}, 32'h0);

        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        check("clr_beats", beats, 32'h0);
        check("clr_frames", frames, 32'h0);

        // Four-beat frame, error marker on the last beat
        for (int i = 1; i <= 4; i++) begin
            tvalid = 1'b1;
            tdata  = 8'(i);
            tlast  = (i == 4);
            tuser  = (i == 4);
            step();
            check($sformatf("mb_in_frame_%0d", i), {31'b0, in_frame}, {31'b0, (i < 4)});
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
        check("mb_beats", beats, 32'h4);
        check("mb_frames", frames, 32'h1);
        check("mb_err_frames", err_frames, 32'h1);

        // Payload changes while stalled
        m_tready = 1'b0;
        tvalid   = 1'b1;
        tdata    = 8'hAA;
        step();
        check("vio_before", {31'b0, proto_err}, 32'h0);
        tdata = 8'hBB;
        step();
        check("vio_set", {31'b0, proto_err}, 32'h1);
        tvalid = 1'b0;
        step();
        step();
        check("vio_sticky", {31'b0, proto_err}, 32'h1);
        check("vio_beats_held", beats, 32'h4);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        check("vio_cleared", {31'b0, proto_err}, 32'h0);

        // Reset in the middle of a frame
        m_tready = 1'b1;
        tvalid   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tdata = 8'(8'h10 + i);
            step();
        end
        check("rf_in_frame", {31'b0, in_frame}, 32'h1);
        check("rf_beats", beats, 32'h2);
        rst = 1'b1;
        #1;
        check("rf_s_tready", {31'b0, s_if.tready}, 32'h0);
        check("rf_m_tvalid", {31'b0, m_if.tvalid}, 32'h0);
        step();
        rst    = 1'b0;
        tvalid = 1'b0;
        check("rf_beats_zero", beats, 32'h0);
        check("rf_frames_zero", frames, 32'h0);
        check("rf_err_zero", err_frames, 32'h0);
        check("rf_in_frame_zero", {31'b0, in_frame}, 32'h0);
        tvalid = 1'b1;
        tlast  = 1'b1;
        step();
        tvalid = 1'b0;
        check("rf_single_frames", frames, 32'h1);
        check("rf_single_in_frame", {31'b0, in_frame}, 32'h0);

        // Clear beats a simultaneous transfer
        tvalid     = 1'b1;
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        tvalid     = 1'b0;
        check("clr_wins_beats", beats, 32'h0);
        check("clr_wins_frames", frames, 32'h0);

        // Twenty single-beat error frames
        tvalid = 1'b1;
        tlast  = 1'b1;
        tuser  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tdata = 8'(i);
            step();
        end
        tvalid = 1'b0;
        tuser  = 1'b0;
        check("sat_frames", {28'b0, sat_frames}, 32'hF);
        check("sat_beats", {28'b0, sat_beats}, 32'hF);
        check("sat_err_frames", {28'b0, sat_err_frames}, 32'hF);
        check("wide_frames", frames, 32'd20);
        check("wide_beats", beats, 32'd20);
        check("wide_in_frame", {31'b0, in_frame}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
